// File: rtl/cla_adder.sv
// Registered WIDTH-bit carry-lookahead adder: {cout,sum} <= a + b + cin.
// Ports: clk, rst_n (async low), a, b, cin -> sum, cout, ovf (CLA_OVF_EN only).
module cla_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NG = WIDTH / 4;
  localparam int LV = (NG > 1) ? $clog2(NG) : 1;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] s;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    gg;
  logic [NG-1:0]    gp;
  logic [NG:0]      gc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar j = 0; j < NG; j++) begin : grp
    localparam int B = 4 * j;
    logic ci;
    assign ci = gc[j];

    assign c[B]   = ci;
    assign c[B+1] = g[B]
                  | (p[B] & ci);
    assign c[B+2] = g[B+1]
                  | (p[B+1] & g[B])
                  | (p[B+1] & p[B] & ci);
    assign c[B+3] = g[B+2]
                  | (p[B+2] & g[B+1])
                  | (p[B+2] & p[B+1] & g[B])
                  | (p[B+2] & p[B+1] & p[B] & ci);

    assign gp[j] = &p[B+:4];
    assign gg[j] = g[B+3]
                 | (p[B+3] & g[B+2])
                 | (p[B+3] & p[B+2] & g[B+1])
                 | (p[B+3] & p[B+2] & p[B+1] & g[B]);
  end

  // Parallel-prefix tree over group (G,P): after the last level,
  // tg[i]/tp[i] span groups 0..i, so each group carry is one AND-OR.
  for (genvar l = 0; l <= LV; l++) begin : lv
    logic [NG-1:0] tg;
    logic [NG-1:0] tp;
    if (l == 0) begin : base
      assign tg = gg;
      assign tp = gp;
    end else begin : comb
      localparam int D = 1 << (l - 1);
      for (genvar i = 0; i < NG; i++) begin : node
        if (i >= D) begin : mrg
          assign tg[i] = lv[l-1].tg[i]
                       | (lv[l-1].tp[i] & lv[l-1].tg[i-D]);
          assign tp[i] = lv[l-1].tp[i] & lv[l-1].tp[i-D];
        end else begin : cpy
          assign tg[i] = lv[l-1].tg[i];
          assign tp[i] = lv[l-1].tp[i];
        end
      end
    end
  end

  assign gc[0] = cin;
  for (genvar j = 0; j < NG; j++) begin : gcar
    assign gc[j+1] = lv[LV].tg[j] | (lv[LV].tp[j] & cin);
  end

  assign c[WIDTH] = gc[NG];
  assign s        = p ^ c[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum  <= '0;
      cout <= 1'b0;
    end else begin
      sum  <= s;
      cout <= c[WIDTH];
    end
  end

`ifdef CLA_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf <= 1'b0;
    else        ovf <= c[WIDTH] ^ c[WIDTH-1];
  end
`endif

endmodule

// File: tb/tb_cla_adder.sv
// Bench for cla_adder: WIDTH=4 sweep and WIDTH=16 random/directed.
// Reference is plain integer addition with sign-rule overflow.
module tb_cla_adder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  a4, b4, s4;
  logic        c4, co4;
  logic [15:0] a16, b16, s16;
  logic        c16, co16;
`ifdef CLA_OVF_EN
  logic        ov4, ov16;
`endif

  int errors = 0;
  int checks = 0;

  cla_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .a(a4), .b(b4), .cin(c4),
    .sum(s4), .cout(co4)
`ifdef CLA_OVF_EN
    , .ovf(ov4)
`endif
  );

  cla_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .a(a16), .b(b16), .cin(c16),
    .sum(s16), .cout(co16)
`ifdef CLA_OVF_EN
    , .ovf(ov16)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_4"}, {27'd0, co4, s4}, 32'd0);
    chk({tag, "_16"}, {15'd0, co16, s16}, 32'd0);
`ifdef CLA_OVF_EN
    chk({tag, "_ovf"}, {30'd0, ov4, ov16}, 32'd0);
`endif
  endtask

  function automatic logic sovf(input int w, input int x,
                                input int y, input int r);
    int sx, sy, sr;
    sx = (x >> (w - 1)) & 1;
    sy = (y >> (w - 1)) & 1;
    sr = (r >> (w - 1)) & 1;
    return (sx == sy) && (sr != sx);
  endfunction

  // Drive both DUTs, let one edge capture, then compare to the model.
  task automatic apply(input string tag,
                       input logic [3:0] xa, input logic [3:0] xb,
                       input logic xc,
                       input logic [15:0] ya, input logic [15:0] yb,
                       input logic yc);
    int e4, e16;
    a4 = xa; b4 = xb; c4 = xc;
    a16 = ya; b16 = yb; c16 = yc;
    e4  = int'(xa) + int'(xb) + int'(xc);
    e16 = int'(ya) + int'(yb) + int'(yc);
    @(posedge clk);
    #1;
    chk({tag, "_4"}, {27'd0, co4, s4}, 32'(e4));
    chk({tag, "_16"}, {15'd0, co16, s16}, 32'(e16));
`ifdef CLA_OVF_EN
    chk({tag, "_ovf4"}, {31'd0, ov4},
        {31'd0, sovf(4, int'(xa), int'(xb), e4)});
    chk({tag, "_ovf16"}, {31'd0, ov16},
        {31'd0, sovf(16, int'(ya), int'(yb), e16)});
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    a4 = 4'hF; b4 = 4'hF; c4 = 1'b1;
    a16 = 16'hFFFF; b16 = 16'hFFFF; c16 = 1'b1;
    #2;
    chk_zero("rst_init");
    #5;
    rst_n = 1'b1;

    apply("d35", 4'h3, 4'h5, 1'b0, 16'h7FFF, 16'h0001, 1'b0);
    apply("dF1", 4'hF, 4'h1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
    apply("dFF1", 4'hF, 4'hF, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    apply("d00", 4'h0, 4'h0, 1'b0, 16'h0000, 16'h0000, 1'b0);
    apply("d16x", 4'h8, 4'h8, 1'b0, 16'h00FF, 16'hFF01, 1'b0);

    for (int i = 0; i < 512; i++) begin
      apply("sweep", 4'(i >> 5), 4'(i >> 1), i[0],
            16'($urandom), 16'($urandom), 1'($urandom));
      if (i == 300) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        @(posedge clk);
        #1;
        chk_zero("rst_hold");
        #2;
        rst_n = 1'b1;
      end
    end

    apply("post", 4'hF, 4'h1, 1'b1, 16'h8000, 16'h8000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
